packet_buffer_read_arbiter: RTL and testbench

// Shares the single read port of packet_buffer_ram_driver between NUM_CLIENTS readers,
// e.g. client 0 = UART dump stream_from_memory, client 1 = Ethernet packet_synth.

---
 rtl/packet_buffer_read_arbiter_pkg.sv | 15 +
 rtl/packet_buffer_read_arbiter_round_robin_picker.sv | 39 +++
 rtl/packet_buffer_read_arbiter.sv | 171 +++++++++++++++++
 tb/tb_packet_buffer_read_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_buffer_read_arbiter_pkg.sv
// rtl/packet_buffer_read_arbiter_pkg.sv - shared constants for the packet buffer read arbiter
package packet_buffer_read_arbiter_pkg;

  localparam int BYTE_LEN                   = 8;
  localparam int PACKET_BUFFER_SIZE         = 2048;
  localparam int PACKET_BUFFER_ADDR_WIDTH   = $clog2(PACKET_BUFFER_SIZE);
  // Worst-case cycles from ram_read_req to ram_read_ready before a read is abandoned
  localparam int PACKET_BUFFER_READ_TIMEOUT = 16;

  // Width of a client index; a single-client build still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packet_buffer_read_arbiter_round_robin_picker.sv
// rtl/packet_buffer_read_arbiter_round_robin_picker.sv - combinational round-robin pick after last index
module round_robin_picker
  import packet_buffer_read_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 2,
  parameter int IDX_W       = idx_width(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   valid_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  // Scan clients starting just after last_i and wrapping; the first requester wins
  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_CLIENTS; off++) begin
      cand = int'(last_i) + off;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      cand_idx = IDX_W'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/packet_buffer_read_arbiter.sv
// rtl/packet_buffer_read_arbiter.sv - round-robin sharing of the packet buffer RAM read port
module packet_buffer_read_arbiter
  import packet_buffer_read_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS    = 2,
  parameter int ADDR_WIDTH     = PACKET_BUFFER_ADDR_WIDTH,
  parameter int DATA_WIDTH     = BYTE_LEN,
  parameter int TIMEOUT_CYCLES = PACKET_BUFFER_READ_TIMEOUT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS-1:0]            client_req,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_addr,
  output logic [NUM_CLIENTS-1:0]            client_ready,
  output logic [DATA_WIDTH-1:0]             client_out,
  output logic [NUM_CLIENTS-1:0]            grant,
  output logic                              ram_read_req,
  output logic [ADDR_WIDTH-1:0]             ram_read_addr,
  input  logic                              ram_read_ready,
  input  logic [DATA_WIDTH-1:0]             ram_read_out,
  output logic                              timeout_err
);

  localparam int IDX_W = idx_width(NUM_CLIENTS);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [NUM_CLIENTS-1:0] mask_q, mask_d;
  logic [NUM_CLIENTS-1:0] ready_q, ready_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   req_q, req_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d;
  logic                   err_q, err_d;

  logic [NUM_CLIENTS-1:0] pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [ADDR_WIDTH-1:0]  pick_addr;
  logic                   timer_expired;

  // The just-served client is masked for one IDLE cycle so its lingering req is not re-granted
  round_robin_picker #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req_i  (client_req & ~mask_q),
    .last_i (last_q),
    .grant_o(pick_grant),
    .idx_o  (pick_idx),
    .valid_o(pick_valid)
  );

  assign timer_expired = (timer_q == TMR_LAST);

  // Select the address of the client about to be granted
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (pick_grant[i]) pick_addr = client_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> WAIT on a pick, WAIT -> DONE on data or back to IDLE on timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (pick_valid) state_d = S_WAIT;
      S_WAIT: begin
        if (ram_read_ready)     state_d = S_DONE;
        else if (timer_expired) state_d = S_IDLE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the grant, address, timer, data and status registers
  always_comb begin
    grant_d = grant_q;
    mask_d  = mask_q;
    ready_d = '0;
    idx_d   = idx_q;
    last_d  = last_q;
    addr_d  = addr_q;
    req_d   = 1'b0;
    timer_d = timer_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        mask_d = '0;
        if (pick_valid) begin
          grant_d = pick_grant;
          idx_d   = pick_idx;
          addr_d  = pick_addr;
          req_d   = 1'b1;
          timer_d = '0;
        end
      end
      S_WAIT: begin
        if (ram_read_ready) begin
          out_d   = ram_read_out;
          ready_d = grant_q;
          last_d  = idx_q;
        end else if (timer_expired) begin
          // Abandon the read but still advance the pointer so no client can starve others
          err_d   = 1'b1;
          grant_d = '0;
          last_d  = idx_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_DONE: begin
        grant_d = '0;
        mask_d  = grant_q;
      end
      default: ;
    endcase
  end

  // Datapath registers; the pointer resets so client 0 wins the first arbitration
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      mask_q  <= '0;
      ready_q <= '0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_CLIENTS - 1);
      addr_q  <= '0;
      req_q   <= 1'b0;
      timer_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      mask_q  <= mask_d;
      ready_q <= ready_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      timer_q <= timer_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign client_ready  = ready_q;
  assign client_out    = out_q;
  assign grant         = grant_q;
  assign ram_read_req  = req_q;
  assign ram_read_addr = addr_q;
  assign timeout_err   = err_q;

endmodule

// File: tb/tb_packet_buffer_read_arbiter.sv
// tb/tb_packet_buffer_read_arbiter.sv - scoreboard bench for the packet buffer read arbiter
module tb_packet_buffer_read_arbiter;

  localparam int N  = 2;
  localparam int AW = 11;
  localparam int DW = 8;

  typedef struct {
    logic [N-1:0]  ready;
    logic [DW-1:0] data;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    client_req;
  logic [N*AW-1:0] client_addr;
  logic [N-1:0]    client_ready;
  logic [DW-1:0]   client_out;
  logic [N-1:0]    grant;
  logic            ram_read_req;
  logic [AW-1:0]   ram_read_addr;
  logic            timeout_err;

  logic            mdl_rdy = 1'b0;
  logic [DW-1:0]   mdl_data = '0;
  logic [AW-1:0]   mdl_addr = '0;
  int              mdl_cnt = 0;
  logic            model_en;
  logic            stray_rdy;
  logic [DW-1:0]   stray_data;

  logic [AW-1:0]   exp_rd[$];
  rsp_t            exp_rsp[$];
  rsp_t            mon_r;

  int checks = 0;
  int failures = 0;
  int rd_count = 0;
  int rdy_count = 0;

  always #5 clk = ~clk;

  packet_buffer_read_arbiter #(
    .NUM_CLIENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .client_req    (client_req),
    .client_addr   (client_addr),
    .client_ready  (client_ready),
    .client_out    (client_out),
    .grant         (grant),
    .ram_read_req  (ram_read_req),
    .ram_read_addr (ram_read_addr),
    .ram_read_ready(mdl_rdy | stray_rdy),
    .ram_read_out  (mdl_rdy ? mdl_data : stray_data),
    .timeout_err   (timeout_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // RAM model, latency 2 from the req cycle, mem[a] = a ^ 0x5A
  always @(negedge clk) begin
    mdl_rdy = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        mdl_rdy  = 1'b1;
        mdl_data = mdl_addr[7:0] ^ 8'h5A;
      end
    end
    if (ram_read_req && model_en) begin
      mdl_cnt  = 2;
      mdl_addr = ram_read_addr;
    end
  end

  // Monitor: every RAM read and every client_ready is matched against the scoreboard
  always @(negedge clk) begin
    if (ram_read_req === 1'b1) begin
      rd_count++;
      if (exp_rd.size() == 0) check_val("rd_unexpected", 32'(exp_rd.size()), 32'd1);
      else check_val("rd_addr", 32'(ram_read_addr), 32'(exp_rd.pop_front()));
    end
    if (client_ready !== '0) begin
      rdy_count++;
      if (exp_rsp.size() == 0) check_val("rdy_unexpected", 32'(client_ready), 32'd0);
      else begin
        mon_r = exp_rsp.pop_front();
        check_val("rdy_owner", 32'(client_ready), 32'(mon_r.ready));
        check_val("rdy_data", 32'(client_out), 32'(mon_r.data));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    client_req = '0;
    repeat (3) tick();
    reset = 1'b0;
    exp_rd.delete();
    exp_rsp.delete();
  endtask

  task automatic push_rsp(input logic [N-1:0] who, input logic [AW-1:0] a);
    rsp_t r;
    r.ready = who;
    r.data  = a[7:0] ^ 8'h5A;
    exp_rsp.push_back(r);
  endtask

  task automatic wait_req(input string tag, output int n);
    n = 0;
    while (ram_read_req !== 1'b1 && n < 40) begin tick(); n++; end
    check_val(tag, 32'(ram_read_req), 32'd1);
  endtask

  task automatic wait_ready(input string tag, output int n);
    n = 0;
    while (client_ready === '0 && n < 60) begin tick(); n++; end
    check_val(tag, 32'(client_ready !== '0), 32'd1);
  endtask

  task automatic check_drained(input string tag);
    check_val({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    check_val({tag, "_rsp_left"}, 32'(exp_rsp.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, rd0, rdy0;
    reset = 1'b1; client_req = '0; client_addr = '0;
    model_en = 1'b1; stray_rdy = 1'b0; stray_data = '0;

    // 1: single read, reset values and latency
    do_reset();
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_ready", 32'(client_ready), 32'd0);
    check_val("rst_req", 32'(ram_read_req), 32'd0);
    check_val("rst_addr", 32'(ram_read_addr), 32'd0);
    check_val("rst_out", 32'(client_out), 32'd0);
    check_val("rst_err", 32'(timeout_err), 32'd0);
    rd0 = rd_count;
    exp_rd.push_back(11'h010); push_rsp(2'b01, 11'h010);
    client_addr[AW-1:0] = 11'h010;
    client_req = 2'b01;
    wait_req("t1_req_seen", n);
    check_val("t1_req_lat", 32'(n), 32'd1);
    check_val("t1_grant", 32'(grant), 32'd1);
    wait_ready("t1_ready_seen", m);
    check_val("t1_ready_lat", 32'(n + m), 32'd4);
    check_val("t1_addr_hold", 32'(ram_read_addr), 32'h010);
    tick(); tick(); client_req = '0;
    repeat (4) tick();
    check_val("t1_reads", 32'(rd_count - rd0), 32'd1);
    check_drained("t1");

    // 2: both clients always requesting alternate 0,1,0,1,...
    do_reset();
    rd0 = rd_count;
    for (int k = 0; k < 3; k++) begin
      exp_rd.push_back(11'h000); push_rsp(2'b01, 11'h000);
      exp_rd.push_back(11'h100); push_rsp(2'b10, 11'h100);
    end
    client_addr = {11'h100, 11'h000};
    client_req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_ready("t2_ready_seen", n);
      if (k == 5) client_req = '0;
      else tick();
    end
    repeat (4) tick();
    check_val("t2_reads", 32'(rd_count - rd0), 32'd6);
    check_drained("t2");

    // 3: client holds req one cycle past ready; the masked cycle must not re-issue
    do_reset();
    rd0 = rd_count; rdy0 = rdy_count;
    for (int k = 0; k < 3; k++) begin
      exp_rd.push_back(AW'(11'h020 + k)); push_rsp(2'b01, AW'(11'h020 + k));
      client_addr[AW-1:0] = AW'(11'h020 + k);
      client_req = 2'b01;
      wait_ready("t3_ready_seen", n);
      tick(); tick();
      client_req = '0;
      tick();
    end
    repeat (3) tick();
    check_val("t3_reads", 32'(rd_count - rd0), 32'd3);
    check_val("t3_readies", 32'(rdy_count - rdy0), 32'd3);
    check_drained("t3");

    // 4: RAM never answers -> timeout, then the retry is served normally
    do_reset();
    model_en = 1'b0;
    rdy0 = rdy_count;
    exp_rd.push_back(11'h030); exp_rd.push_back(11'h030); push_rsp(2'b01, 11'h030);
    client_addr[AW-1:0] = 11'h030;
    client_req = 2'b01;
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin tick(); n++; end
    check_val("t4_err_lat", 32'(n), 32'd17);
    check_val("t4_grant_clr", 32'(grant), 32'd0);
    check_val("t4_no_ready", 32'(rdy_count - rdy0), 32'd0);
    model_en = 1'b1;
    wait_ready("t4_retry_ready", m);
    tick(); tick(); client_req = '0;
    repeat (3) tick();
    check_val("t4_err_sticky", 32'(timeout_err), 32'd1);
    check_drained("t4");

    // 5: reset during WAIT, RAM answers afterwards
    do_reset();
    rdy0 = rdy_count;
    exp_rd.push_back(11'h040);
    client_addr = {11'h141, 11'h040};
    client_req = 2'b01;
    wait_req("t5_req_seen", n);
    reset = 1'b1; client_req = '0;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check_val("t5_no_ready", 32'(rdy_count - rdy0), 32'd0);
    check_val("t5_grant", 32'(grant), 32'd0);
    check_val("t5_out", 32'(client_out), 32'd0);
    check_val("t5_addr", 32'(ram_read_addr), 32'd0);
    check_val("t5_err", 32'(timeout_err), 32'd0);
    exp_rd.push_back(11'h040); push_rsp(2'b01, 11'h040);
    exp_rd.push_back(11'h141); push_rsp(2'b10, 11'h141);
    client_req = 2'b11;
    wait_ready("t5_first_seen", n);
    check_val("t5_first_owner", 32'(client_ready), 32'd1);
    tick();
    wait_ready("t5_second_seen", n);
    client_req = '0;
    repeat (4) tick();
    check_drained("t5");

    // 6: stray ready in IDLE, client 1 drops req mid-WAIT
    do_reset();
    rdy0 = rdy_count;
    stray_data = 8'hEE; stray_rdy = 1'b1;
    tick();
    stray_rdy = 1'b0;
    repeat (3) tick();
    check_val("t6_stray_ready", 32'(rdy_count - rdy0), 32'd0);
    check_val("t6_stray_out", 32'(client_out), 32'd0);
    check_val("t6_stray_err", 32'(timeout_err), 32'd0);
    exp_rd.push_back(11'h123); push_rsp(2'b10, 11'h123);
    client_addr[2*AW-1:AW] = 11'h123;
    client_req = 2'b10;
    wait_req("t6_req_seen", n);
    tick();
    client_req = '0;
    wait_ready("t6_ready_seen", m);
    repeat (4) tick();
    check_val("t6_readies", 32'(rdy_count - rdy0), 32'd1);
    check_drained("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
